// File: rtl/instruction_control_sequencer.sv
// RV32I instruction control sequencer: accepts one instruction at a time, decodes its
// operand/write-back selects and sequences memory waits, fences and illegal-opcode traps.
module instruction_control_sequencer #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned FENCE_CYCLES = 2,
    parameter int unsigned ILLEGAL_TRAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [2:0]  alu_a_src,
    output logic [2:0]  alu_b_src,
    output logic [1:0]  reg_write_src,
    output logic        retire,
    output logic        illegal,
    output logic        timeout
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_FENCE, S_HALT} state_e;
    typedef enum logic [2:0] {K_ILLEGAL, K_WB, K_BRANCH, K_LOAD, K_STORE, K_FENCE} kind_e;

    localparam logic [2:0] SRC_ZERO  = 3'd0;
    localparam logic [2:0] SRC_PC4   = 3'd1;
    localparam logic [2:0] SRC_PC    = 3'd2;
    localparam logic [2:0] SRC_REG   = 3'd3;
    localparam logic [2:0] SRC_IMM12 = 3'd4;
    localparam logic [2:0] SRC_IMM20 = 3'd5;
    localparam logic [1:0] WB_NONE   = 2'd0;
    localparam logic [1:0] WB_ALU    = 2'd1;
    localparam logic [1:0] WB_MEM    = 2'd2;
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [3:0] FENCE_LAST = 4'(FENCE_CYCLES - 1);

    state_e      state_q;
    logic [31:0] instr_q;
    logic [7:0]  wait_q;
    logic [3:0]  fence_q;

    kind_e       kind;
    logic [2:0]  dec_a;
    logic [2:0]  dec_b;
    logic [1:0]  dec_ws;
    logic        rd_nz;
    logic        wait_last;
    logic        fence_last;
    logic        unused_bits;

    assign rs1_addr    = instr_q[19:15];
    assign rs2_addr    = instr_q[24:20];
    assign rd_addr     = instr_q[11:7];
    assign rd_nz       = (instr_q[11:7] != 5'd0);
    assign wait_last   = (wait_q == WAIT_LAST);
    assign fence_last  = (fence_q == FENCE_LAST);
    assign unused_bits = ^{instr_q[31:25], instr_q[14:12]};

    always_comb begin
        kind   = K_ILLEGAL;
        dec_a  = SRC_ZERO;
        dec_b  = SRC_ZERO;
        dec_ws = WB_NONE;
        if (instr_q[1:0] == 2'b11) begin
            case (instr_q[6:2])
                5'h00: begin kind = K_LOAD;   dec_a = SRC_REG;  dec_b = SRC_IMM12; dec_ws = WB_MEM; end
                5'h08: begin kind = K_STORE;  dec_a = SRC_REG;  dec_b = SRC_IMM12; end
                5'h04: begin kind = K_WB;     dec_a = SRC_REG;  dec_b = SRC_IMM12; dec_ws = WB_ALU; end
                5'h0C: begin kind = K_WB;     dec_a = SRC_REG;  dec_b = SRC_REG;   dec_ws = WB_ALU; end
                5'h05: begin kind = K_WB;     dec_a = SRC_PC;   dec_b = SRC_IMM20; dec_ws = WB_ALU; end
                5'h0D: begin kind = K_WB;     dec_a = SRC_ZERO; dec_b = SRC_IMM20; dec_ws = WB_ALU; end
                5'h19,
                5'h1B: begin kind = K_WB;     dec_a = SRC_PC4;  dec_b = SRC_ZERO;  dec_ws = WB_ALU; end
                5'h18: begin kind = K_BRANCH; dec_a = SRC_REG;  dec_b = SRC_REG;   end
                5'h03: begin kind = K_FENCE; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            wait_q  <= '0;
            fence_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (instr_valid) begin
                    instr_q <= instr;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wait_q  <= '0;
                    fence_q <= '0;
                    case (kind)
                        K_LOAD, K_STORE: state_q <= S_MEM_WAIT;
                        K_FENCE:   state_q <= (FENCE_CYCLES == 0) ? S_IDLE : S_FENCE;
                        K_ILLEGAL: state_q <= (ILLEGAL_TRAP != 0) ? S_HALT : S_IDLE;
                        default:   state_q <= S_IDLE;
                    endcase
                end
                S_MEM_WAIT: begin
                    if (mem_ack || wait_last) state_q <= S_IDLE;
                    else wait_q <= wait_q + 8'd1;
                end
                S_FENCE: begin
                    if (fence_last) state_q <= S_IDLE;
                    else fence_q <= fence_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Ack-cycle retire/reg_we must follow mem_ack in the same cycle, so strobes are decoded from state.
    always_comb begin
        instr_ready   = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_we        = 1'b0;
        alu_a_src     = SRC_ZERO;
        alu_b_src     = SRC_ZERO;
        reg_write_src = WB_NONE;
        retire        = 1'b0;
        illegal       = 1'b0;
        timeout       = 1'b0;
        case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                alu_a_src     = dec_a;
                alu_b_src     = dec_b;
                reg_write_src = dec_ws;
                case (kind)
                    K_WB:      begin reg_we = rd_nz; retire = 1'b1; end
                    K_BRANCH:  retire = 1'b1;
                    K_FENCE:   retire = (FENCE_CYCLES == 0);
                    K_ILLEGAL: begin illegal = 1'b1; retire = (ILLEGAL_TRAP == 0); end
                    default: ;
                endcase
            end
            S_MEM_WAIT: begin
                alu_a_src     = dec_a;
                alu_b_src     = dec_b;
                reg_write_src = dec_ws;
                mem_req       = 1'b1;
                mem_we        = (kind == K_STORE);
                if (mem_ack) begin
                    retire = 1'b1;
                    reg_we = (kind == K_LOAD) && rd_nz;
                end else begin
                    timeout = wait_last;
                end
            end
            S_FENCE: retire = fence_last;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_instruction_control_sequencer.sv
// Self-checking bench for instruction_control_sequencer: directed scenarios plus random
// instruction streams checked against a per-instruction behavioural model.
module tb_instruction_control_sequencer;
    localparam int unsigned TO = 4;
    localparam int unsigned FC = 2;
    localparam logic [2:0] K_WB = 3'd0, K_BR = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_FN = 3'd4, K_IL = 3'd5;
    localparam logic [14:0] IDLE_P = 15'h4000;

    logic        clk = 1'b0;
    logic        reset, instr_valid, instr_ready, mem_ack, mem_req, mem_we, reg_we;
    logic        retire, illegal, timeout;
    logic [31:0] instr;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  alu_a_src, alu_b_src;
    logic [1:0]  reg_write_src;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  ops [10] = '{5'h00, 5'h08, 5'h04, 5'h0C, 5'h05, 5'h0D, 5'h19, 5'h1B, 5'h18, 5'h03};

    instruction_control_sequencer #(
        .MEM_TIMEOUT(TO),
        .FENCE_CYCLES(FC),
        .ILLEGAL_TRAP(1)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .reg_we(reg_we), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .reg_write_src(reg_write_src),
        .retire(retire), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] ws;
    } ref_t;

    // Opcode table: class, operand A, operand B, write-back source.
    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t r;
        r = '{K_IL, 3'd0, 3'd0, 2'd0};
        if (ins[1:0] == 2'b11) begin
            case (ins[6:2])
                5'h00: r = '{K_LD, 3'd3, 3'd4, 2'd2};
                5'h08: r = '{K_ST, 3'd3, 3'd4, 2'd0};
                5'h04: r = '{K_WB, 3'd3, 3'd4, 2'd1};
                5'h0C: r = '{K_WB, 3'd3, 3'd3, 2'd1};
                5'h05: r = '{K_WB, 3'd2, 3'd5, 2'd1};
                5'h0D: r = '{K_WB, 3'd0, 3'd5, 2'd1};
                5'h19, 5'h1B: r = '{K_WB, 3'd1, 3'd0, 2'd1};
                5'h18: r = '{K_BR, 3'd3, 3'd3, 2'd0};
                5'h03: r = '{K_FN, 3'd0, 3'd0, 2'd0};
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic logic [14:0] pk(input logic rdy, mreq, mwe, rwe, input logic [2:0] a, b,
                                       input logic [1:0] ws, input logic ret, ill, to);
        return {rdy, mreq, mwe, rwe, a, b, ws, ret, ill, to};
    endfunction

    function automatic logic [14:0] obs_all();
        return pk(instr_ready, mem_req, mem_we, reg_we, alu_a_src, alu_b_src, reg_write_src,
                  retire, illegal, timeout);
    endfunction

    function automatic logic [14:0] obs_nosel();
        return pk(instr_ready, mem_req, mem_we, reg_we, 3'd0, 3'd0, 2'd0, retire, illegal, timeout);
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_idle", obs_all(), IDLE_P);
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge back in idle.
    // d = number of ack-less wait cycles before mem_ack (d >= TO means no ack).
    task automatic run_instr(input logic [31:0] ins, input int unsigned d, input string nm);
        ref_t r;
        logic rdnz, ack, ret, rwe, to;
        r = ref_decode(ins);
        rdnz = (ins[11:7] != 5'd0);
        instr_valid = 1'b1;
        instr = ins;
        mem_ack = 1'($urandom_range(0, 1));
        #1 chk({nm, ":ready"}, obs_all(), IDLE_P);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = $urandom;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        ret = (r.kind == K_WB) || (r.kind == K_BR) || (r.kind == K_FN && FC == 0);
        rwe = (r.kind == K_WB) && rdnz;
        chk({nm, ":exec"}, obs_all(), pk(1'b0, 1'b0, 1'b0, rwe, r.a, r.b, r.ws, ret, 1'b0, 1'b0));
        chk({nm, ":addr"}, {rs1_addr, rs2_addr, rd_addr}, {ins[19:15], ins[24:20], ins[11:7]});
        if (r.kind == K_LD || r.kind == K_ST) begin
            for (int unsigned w = 0; w < TO; w++) begin
                @(posedge clk);
                ack = (w == d);
                #1 mem_ack = ack;
                @(negedge clk);
                rwe = ack && (r.kind == K_LD) && rdnz;
                to = !ack && (w == TO - 1);
                chk({nm, ":wait"}, obs_nosel(),
                    pk(1'b0, 1'b1, r.kind == K_ST, rwe, 3'd0, 3'd0, 2'd0, ack, 1'b0, to));
                if (ack) break;
            end
        end else if (r.kind == K_FN) begin
            for (int unsigned f = 0; f < FC; f++) begin
                @(posedge clk);
                #1 mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk({nm, ":fence"}, obs_all(),
                    pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, f == FC - 1, 1'b0, 1'b0));
            end
        end
        @(posedge clk);
        #1 mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({nm, ":after"}, obs_all(), IDLE_P);
    endtask

    initial begin
        logic [31:0] rnd;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", obs_all(), IDLE_P);
        chk("reset_addr", {rs1_addr, rs2_addr, rd_addr}, 15'd0);

        run_instr(32'h00500293, 0, "addi_x5");
        run_instr(32'h0000A303, 3, "lw_ack3");
        run_instr(32'h0000A303, 1, "lw_ack1");
        run_instr(32'h0020A023, TO, "sw_timeout");
        run_instr(32'h0020A023, 0, "sw_ack0");
        run_instr(32'h0000000F, 0, "fence");
        run_instr(32'h00000037, 0, "lui_x0");
        run_instr(32'h00000063, 0, "beq");
        run_instr(32'h000000EF, 0, "jal_x1");

        // Reset while waiting for an ack: no retire or timeout may follow.
        instr_valid = 1'b1;
        instr = 32'h0000A303;
        mem_ack = 1'b0;
        #1 chk("rstmw:ready", obs_all(), IDLE_P);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstmw:wait0", obs_nosel(), 15'h2000);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rstmw:during", obs_nosel(), 15'h2000);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("rstmw:idle", obs_all(), IDLE_P);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("rstmw:quiet", obs_all(), IDLE_P);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            run_instr({rnd[31:7], ops[$urandom_range(0, 9)], 2'b11}, $urandom_range(0, TO), "rand");
        end

        // Unsupported opcode 0x7F halts until reset, even with new instructions offered.
        instr_valid = 1'b1;
        instr = 32'h0000007F;
        #1 chk("ill7f:ready", obs_all(), IDLE_P);
        @(posedge clk);
        #1 instr = 32'h00500293;
        @(negedge clk);
        chk("ill7f:exec", obs_all(), 15'h0002);
        repeat (5) begin
            @(posedge clk);
            #1 mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("ill7f:halt", obs_all(), 15'h0000);
        end
        do_reset();
        run_instr(32'h00500293, 0, "post_halt_addi");

        // Low opcode bits other than 2'b11 are also unsupported.
        instr_valid = 1'b1;
        instr = 32'h00500291;
        #1 chk("ill01:ready", obs_all(), IDLE_P);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("ill01:exec", obs_all(), 15'h0002);
        @(posedge clk);
        @(negedge clk);
        chk("ill01:halt", obs_all(), 15'h0000);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
